instr_fetch_queue: RTL and testbench

//  Parametrised instruction fetch queue between the icache and the decoder.
//  - Generates sequential fetch PCs and holds at most one outstanding icache request.
//  - Buffers returned {pc, instr} pairs in a DEPTH-entry ring.
//  - Presents them to the decoder through a registered valid/ready output stage.
//  - Supports ROB redirects, with discard of any stale in-flight response.

---
 rtl/instr_fetch_queue_pkg.sv | 13 +
 rtl/instr_fetch_queue_ring.sv | 47 ++++
 rtl/instr_fetch_queue.sv | 110 +++++++++++
 tb/tb_instr_fetch_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: fetch FSM states and default geometry.
package instr_fetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH_DEFAULT    = 16;
  localparam logic [31:0] IFQ_RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/instr_fetch_queue_ring.sv
// Ring buffer for fetched {pc, instr} entries: storage, wrap-bit pointers, flags, synchronous clear.
module ifq_ring #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4,
  parameter int unsigned W     = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           we,
  input  logic [W-1:0]   wdata,
  input  logic           re,
  output logic [W-1:0]   rdata,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W:0] head;
  logic [PTR_W:0] tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (we) tail <= tail + PTR_ONE;
      if (re) head <= head + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !clr) mem[tail[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem[head[PTR_W-1:0]];
  assign empty = (head == tail);
  assign full  = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
  assign count = tail - head;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: single-outstanding icache fetch FSM, ring buffer, registered decoder stage.
// Optional icache-to-decoder bypass of an empty ring when IFQ_BYPASS_EN is defined.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = IFQ_DEPTH_DEFAULT,
  parameter int unsigned     PTR_W    = 4,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFQ_RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_from_rob,
  input  logic [PC_W-1:0]    pc_from_rob,
  output logic               req_to_ic,
  output logic [PC_W-1:0]    pc_to_ic,
  input  logic               is_hit_from_ic,
  input  logic [INSTR_W-1:0] instr_from_ic,
  output logic               valid_to_dc,
  input  logic               ready_from_dc,
  output logic [INSTR_W-1:0] instr_to_dc,
  output logic [PC_W-1:0]    pc_to_dc,
  output logic [PTR_W:0]     count
);

  ifq_state_e                 state_q, state_d;
  logic [PC_W-1:0]            fetch_pc;
  logic                       hit_w;
  logic                       byp;
  logic                       ring_we, ring_re;
  logic                       ring_empty, ring_full;
  logic [PC_W+INSTR_W-1:0]    ring_rdata;

  assign hit_w = (state_q == IFQ_WAIT) && is_hit_from_ic;

`ifdef IFQ_BYPASS_EN
  assign byp = hit_w && ring_empty && (!valid_to_dc || ready_from_dc);
`else
  assign byp = 1'b0;
`endif

  assign ring_we   = hit_w && !flush_from_rob && !byp;
  assign ring_re   = !ring_empty && (!valid_to_dc || ready_from_dc) && !flush_from_rob;
  assign req_to_ic = (state_q == IFQ_WAIT);
  assign pc_to_ic  = fetch_pc;

  ifq_ring #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (PC_W + INSTR_W)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_from_rob),
    .we    (ring_we),
    .wdata ({fetch_pc, instr_from_ic}),
    .re    (ring_re),
    .rdata (ring_rdata),
    .empty (ring_empty),
    .full  (ring_full),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IFQ_IDLE;
    else      state_q <= state_d;
  end

  // A flush parks an unanswered request in DROP so its eventual hit is swallowed.
  always_comb begin
    state_d = state_q;
    if (flush_from_rob) begin
      if (state_q == IFQ_WAIT) state_d = is_hit_from_ic ? IFQ_IDLE : IFQ_DROP;
    end else begin
      case (state_q)
        IFQ_IDLE: if (!ring_full)     state_d = IFQ_WAIT;
        IFQ_WAIT: if (is_hit_from_ic) state_d = IFQ_IDLE;
        IFQ_DROP: if (is_hit_from_ic) state_d = IFQ_IDLE;
        default:                      state_d = IFQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                fetch_pc <= RESET_PC;
    else if (flush_from_rob) fetch_pc <= pc_from_rob;
    else if (hit_w)          fetch_pc <= fetch_pc + PC_W'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_to_dc <= 1'b0;
      instr_to_dc <= '0;
      pc_to_dc    <= '0;
    end else if (flush_from_rob) begin
      valid_to_dc <= 1'b0;
    end else if (byp) begin
      valid_to_dc <= 1'b1;
      pc_to_dc    <= fetch_pc;
      instr_to_dc <= instr_from_ic;
    end else if (ring_re) begin
      valid_to_dc <= 1'b1;
      {pc_to_dc, instr_to_dc} <= ring_rdata;
    end else if (ready_from_dc) begin
      valid_to_dc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: icache responder plus an in-order {pc, instr} scoreboard.
module tb_instr_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_from_rob;
  logic [31:0] pc_from_rob;
  logic        req_to_ic;
  logic [31:0] pc_to_ic;
  logic        is_hit_from_ic;
  logic [31:0] instr_from_ic;
  logic        valid_to_dc;
  logic        ready_from_dc;
  logic [31:0] instr_to_dc;
  logic [31:0] pc_to_dc;
  logic [4:0]  count;

  instr_fetch_queue #(
    .DEPTH    (16),
    .PTR_W    (4),
    .INSTR_W  (32),
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_from_rob (flush_from_rob),
    .pc_from_rob    (pc_from_rob),
    .req_to_ic      (req_to_ic),
    .pc_to_ic       (pc_to_ic),
    .is_hit_from_ic (is_hit_from_ic),
    .instr_from_ic  (instr_from_ic),
    .valid_to_dc    (valid_to_dc),
    .ready_from_dc  (ready_from_dc),
    .instr_to_dc    (instr_to_dc),
    .pc_to_dc       (pc_to_dc),
    .count          (count)
  );

  always #5 clk = ~clk;

`ifdef IFQ_BYPASS_EN
  localparam int HIT_TO_VALID = 1;
`else
  localparam int HIT_TO_VALID = 2;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_xfer = 0;
  ent_t        q[$];
  logic [31:0] exp_pc = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  int          pend_cnt = 0;
  int          delay_stim = 0;
  logic        ready_stim = 1'b0;
  logic        flush_stim = 1'b0;
  logic [31:0] target_stim = 32'h0;
  logic        flush_on_hit = 1'b0;
  logic        hit_acc = 1'b0;
  logic        new_req = 1'b0;

  function automatic logic [31:0] ifn(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: check observed state, act as the icache, drive inputs, then advance the reference model.
  task automatic cycle();
    logic hit, fl;
    @(negedge clk);
    cyc++;
    chk("occupancy", 64'(count) + 64'(valid_to_dc), 64'(q.size()));
    if (valid_to_dc && q.size() > 0) begin
      chk("pc_to_dc", 64'(pc_to_dc), 64'(q[0].pc));
      chk("instr_to_dc", 64'(instr_to_dc), 64'(q[0].instr));
    end
    new_req = 1'b0;
    if (req_to_ic && !pend) begin
      chk("pc_to_ic", 64'(pc_to_ic), 64'(exp_pc));
      pend = 1'b1; pend_pc = pc_to_ic; pend_cnt = delay_stim; new_req = 1'b1;
    end
    hit = pend && (pend_cnt == 0);
    fl  = flush_stim;
    if (flush_on_hit && hit && req_to_ic) begin
      fl = 1'b1;
      flush_on_hit = 1'b0;
    end
    if (hit && !req_to_ic) fl = 1'b0;
    is_hit_from_ic = hit;
    instr_from_ic  = hit ? ifn(pend_pc) : 32'h0;
    flush_from_rob = fl;
    pc_from_rob    = target_stim;
    ready_from_dc  = ready_stim;
    hit_acc = 1'b0;
    if (valid_to_dc && ready_stim) begin
      if (q.size() > 0) void'(q.pop_front());
      n_xfer++;
    end
    if (hit) begin
      if (req_to_ic && !fl) begin
        q.push_back('{pc: pend_pc, instr: ifn(pend_pc)});
        exp_pc  = pend_pc + 32'd4;
        hit_acc = 1'b1;
      end
      pend = 1'b0;
    end else if (pend) begin
      pend_cnt--;
    end
    if (fl) begin
      q.delete();
      exp_pc = target_stim;
    end
  endtask

  initial begin
    int          h;
    int          k;
    logic [31:0] hold_pc, hold_instr;

    rst = 1'b0; flush_from_rob = 1'b0; pc_from_rob = '0;
    is_hit_from_ic = 1'b0; instr_from_ic = '0; ready_from_dc = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req_to_ic), 64'd0);
    chk("rst_valid", 64'(valid_to_dc), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc_to_dc", 64'(pc_to_dc), 64'd0);
    chk("rst_instr_to_dc", 64'(instr_to_dc), 64'd0);
    chk("rst_pc_to_ic", 64'(pc_to_ic), 64'd0);
    rst = 1'b1;

    // Latency from hit to decoder-visible valid on an empty queue.
    ready_stim = 1'b1; delay_stim = 0;
    for (k = 0; k < 10 && !hit_acc; k++) cycle();
    chk("first_hit_seen", 64'(hit_acc), 64'd1);
    h = cyc;
    for (k = 0; k < 6; k++) begin
      cycle();
      if (valid_to_dc) break;
    end
    chk("hit_to_valid", 64'(cyc - h), 64'(HIT_TO_VALID));
    chk("latency_count", 64'(count), 64'd0);

    // Sequential fetch with one-cycle icache response.
    delay_stim = 1; n_xfer = 0;
    repeat (40) cycle();
    chk("seq_throughput", 64'(n_xfer >= 10), 64'd1);

    // Decoder stalled: ring fills, fetch stops, output stage holds.
    ready_stim = 1'b0; delay_stim = 0;
    repeat (60) cycle();
    chk("full_count", 64'(count), 64'd16);
    chk("full_no_req", 64'(req_to_ic), 64'd0);
    chk("full_valid", 64'(valid_to_dc), 64'd1);
    hold_pc = pc_to_dc; hold_instr = instr_to_dc;
    repeat (5) cycle();
    chk("stall_pc", 64'(pc_to_dc), 64'(hold_pc));
    chk("stall_instr", 64'(instr_to_dc), 64'(hold_instr));
    ready_stim = 1'b1;
    cycle();
    ready_stim = 1'b0;
    cycle();
    chk("single_xfer_pc", 64'(pc_to_dc), 64'(hold_pc + 32'd4));
    ready_stim = 1'b1;
    repeat (60) cycle();

    // Flush while a request waits on a slow icache.
    delay_stim = 3; target_stim = 32'h1000;
    for (k = 0; k < 20; k++) begin
      cycle();
      if (new_req) break;
    end
    chk("slow_req_seen", 64'(new_req), 64'd1);
    flush_stim = 1'b1;
    cycle();
    flush_stim = 1'b0;
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(valid_to_dc), 64'd0);
    for (k = 0; k < 20; k++) begin
      cycle();
      if (new_req) break;
    end
    chk("post_flush_req", 64'(new_req), 64'd1);
    chk("post_flush_pc", 64'(pc_to_ic), 64'h1000);

    // Flush landing in the same cycle as a hit.
    delay_stim = 0; ready_stim = 1'b0;
    repeat (6) cycle();
    flush_on_hit = 1'b1;
    for (k = 0; k < 20 && flush_on_hit; k++) cycle();
    chk("flush_hit_armed", 64'(flush_on_hit), 64'd0);
    cycle();
    chk("flush_hit_valid", 64'(valid_to_dc), 64'd0);
    chk("flush_hit_idle", 64'(req_to_ic), 64'd0);
    chk("flush_hit_count", 64'(count), 64'd0);
    ready_stim = 1'b1;
    for (k = 0; k < 20; k++) begin
      cycle();
      if (new_req) break;
    end
    chk("flush_hit_req", 64'(new_req), 64'd1);
    chk("flush_hit_pc", 64'(pc_to_ic), 64'h1000);

    // Random traffic: decoder backpressure, icache delay, occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      ready_stim  = ($urandom_range(0, 9) < 7);
      delay_stim  = $urandom_range(0, 3);
      flush_stim  = ($urandom_range(0, 39) == 0);
      target_stim = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    flush_stim = 1'b0; ready_stim = 1'b1;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
